// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter serialising start, DATA_WIDTH data bits
// (LSB first), optional parity and one stop bit, each held Prescale CLK
// cycles. Synchronous active-low reset; all outputs registered.
// Optional macro UART_TX_HOLD_EN adds a one-entry holding register so a
// following word can be queued and sent with no idle gap.
module uart_tx_frame #(
  parameter int DATA_WIDTH  = 8,
  parameter int PRESC_WIDTH = 6
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [DATA_WIDTH-1:0]  P_DATA,
  input  logic                   Data_Valid,
  input  logic                   PAR_EN,
  input  logic                   PAR_TYP,
  input  logic [PRESC_WIDTH-1:0] Prescale,
  output logic                   TX_OUT,
  output logic                   Busy,
  output logic                   Data_Ready
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state_q, state_n;
  logic [PRESC_WIDTH-1:0] edge_q, edge_n;
  logic [BW-1:0]          bit_q, bit_n;
  logic [DATA_WIDTH-1:0]  data_q, data_n;
  logic                   par_en_q, par_en_n;
  logic                   par_typ_q, par_typ_n;
  logic [PRESC_WIDTH-1:0] presc_q, presc_n;
  logic                   tx_n, busy_n, ready_n;
  logic                   accept, edge_last, load_in;
`ifdef UART_TX_HOLD_EN
  logic                   hold_full_q, hold_full_n;
  logic [DATA_WIDTH-1:0]  hold_data_q, hold_data_n;
  logic                   hold_par_en_q, hold_par_en_n;
  logic                   hold_par_typ_q, hold_par_typ_n;
  logic                   load_hold;
`endif

  // Next-state, counters, word loading and registered-output values
  always_comb begin
    state_n   = state_q;
    edge_n    = edge_q;
    bit_n     = bit_q;
    data_n    = data_q;
    par_en_n  = par_en_q;
    par_typ_n = par_typ_q;
    presc_n   = presc_q;
    load_in   = 1'b0;
    accept    = Data_Valid & Data_Ready;
    edge_last = (edge_q == presc_q - PRESC_WIDTH'(1));
`ifdef UART_TX_HOLD_EN
    load_hold      = 1'b0;
    hold_full_n    = hold_full_q;
    hold_data_n    = hold_data_q;
    hold_par_en_n  = hold_par_en_q;
    hold_par_typ_n = hold_par_typ_q;
`endif

    case (state_q)
      IDLE: begin
`ifdef UART_TX_HOLD_EN
        if (hold_full_q) load_hold = 1'b1;
        else if (accept) load_in = 1'b1;
`else
        if (accept) load_in = 1'b1;
`endif
      end
      START, DATA, PARITY, STOP: begin
        edge_n = edge_last ? '0 : edge_q + PRESC_WIDTH'(1);
        if (edge_last) begin
          case (state_q)
            START: begin
              state_n = DATA;
              bit_n   = '0;
            end
            DATA: begin
              if (bit_q == LAST_BIT) state_n = par_en_q ? PARITY : STOP;
              else                   bit_n   = bit_q + BW'(1);
            end
            PARITY: state_n = STOP;
            default: begin
`ifdef UART_TX_HOLD_EN
              // Queued word goes first; a word offered now lands in hold.
              if (hold_full_q) load_hold = 1'b1;
              else if (accept) load_in = 1'b1;
              else             state_n = IDLE;
`else
              state_n = IDLE;
`endif
            end
          endcase
        end
      end
      default: state_n = IDLE;
    endcase

    if (load_in) begin
      data_n    = P_DATA;
      par_en_n  = PAR_EN;
      par_typ_n = PAR_TYP;
      presc_n   = (Prescale < PRESC_WIDTH'(2)) ? PRESC_WIDTH'(2) : Prescale;
      state_n   = START;
      edge_n    = '0;
      bit_n     = '0;
    end

`ifdef UART_TX_HOLD_EN
    if (load_hold) begin
      data_n      = hold_data_q;
      par_en_n    = hold_par_en_q;
      par_typ_n   = hold_par_typ_q;
      state_n     = START;
      edge_n      = '0;
      bit_n       = '0;
      hold_full_n = 1'b0;
    end
    if (accept && !load_in) begin
      hold_full_n    = 1'b1;
      hold_data_n    = P_DATA;
      hold_par_en_n  = PAR_EN;
      hold_par_typ_n = PAR_TYP;
    end
`endif

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = data_n[bit_n];
      PARITY:  tx_n = par_typ_n ? ~^data_n : ^data_n;
      default: tx_n = 1'b1;
    endcase
    busy_n = (state_n != IDLE);
`ifdef UART_TX_HOLD_EN
    ready_n = ~hold_full_n;
`else
    ready_n = ~busy_n;
`endif
  end

  // State, counters, latched frame settings and registered outputs
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= IDLE;
      edge_q     <= '0;
      bit_q      <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      presc_q    <= PRESC_WIDTH'(2);
      TX_OUT     <= 1'b1;
      Busy       <= 1'b0;
      Data_Ready <= 1'b1;
`ifdef UART_TX_HOLD_EN
      hold_full_q    <= 1'b0;
      hold_data_q    <= '0;
      hold_par_en_q  <= 1'b0;
      hold_par_typ_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_n;
      edge_q     <= edge_n;
      bit_q      <= bit_n;
      data_q     <= data_n;
      par_en_q   <= par_en_n;
      par_typ_q  <= par_typ_n;
      presc_q    <= presc_n;
      TX_OUT     <= tx_n;
      Busy       <= busy_n;
      Data_Ready <= ready_n;
`ifdef UART_TX_HOLD_EN
      hold_full_q    <= hold_full_n;
      hold_data_q    <= hold_data_n;
      hold_par_en_q  <= hold_par_en_n;
      hold_par_typ_q <= hold_par_typ_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed testbench for uart_tx_frame. Inputs change and
// outputs are sampled on the CLK falling edge. Expected frames are written
// as hand-built vectors: bit 0 = start, then data LSB first, parity, stop.
module tb_uart_tx_frame;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic       TX_OUT;
  logic       Busy;
  logic       Data_Ready;

  int errors;
  int checks;

  uart_tx_frame #(.DATA_WIDTH(8), .PRESC_WIDTH(6)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .Prescale(Prescale),
    .TX_OUT(TX_OUT), .Busy(Busy), .Data_Ready(Data_Ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Present one word for a single cycle; returns at the falling edge where
  // the start bit is first visible.
  task automatic send_word(input logic [7:0] d, input logic pen,
                           input logic ptyp, input logic [5:0] p);
    P_DATA = d; PAR_EN = pen; PAR_TYP = ptyp; Prescale = p; Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b0; Data_Valid = 1'b0; P_DATA = '0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    Prescale = 6'd8;
    repeat (4) @(negedge CLK);
    checks++;
    if (TX_OUT !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", TX_OUT); end
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
    checks++;
    if (Data_Ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", Data_Ready); end
    // Word offered while reset is asserted must not be taken
    P_DATA = 8'h12; Data_Valid = 1'b1;
    @(negedge CLK);
    RST = 1'b1; Data_Valid = 1'b0;
    @(negedge CLK);
    checks++;
    if (Busy !== 1'b0 || TX_OUT !== 1'b1) begin
      errors++; $display("FAIL reset_wins: Busy=%b TX_OUT=%b want 0 1", Busy, TX_OUT);
    end
  endtask

  task automatic test_frame_a5;
    logic [10:0] exp;
    exp = {1'b1, 1'b0, 8'hA5, 1'b0};
    send_word(8'hA5, 1'b1, 1'b0, 6'd8);
    Prescale = 6'd3;  // must not affect the frame in flight
    for (int i = 0; i < 11; i++) begin
      for (int c = 0; c < 8; c++) begin
        checks++;
        if (TX_OUT !== exp[i] || Busy !== 1'b1 || Data_Ready !== 1'b0) begin
          errors++;
          $display("FAIL a5_frame bit %0d cyc %0d: TX_OUT=%b Busy=%b Ready=%b want %b 1 0",
                   i, c, TX_OUT, Busy, Data_Ready, exp[i]);
        end
        @(negedge CLK);
      end
    end
    checks++;
    if (Busy !== 1'b0 || TX_OUT !== 1'b1 || Data_Ready !== 1'b1) begin
      errors++;
      $display("FAIL a5_end: Busy=%b TX_OUT=%b Ready=%b want 0 1 1", Busy, TX_OUT, Data_Ready);
    end
  endtask

  task automatic test_parity;
    logic [10:0] exp;
    for (int t = 0; t < 2; t++) begin
      // 0x01 has one set bit: odd type -> parity 0, even type -> parity 1
      exp = (t == 0) ? {1'b1, 1'b0, 8'h01, 1'b0} : {1'b1, 1'b1, 8'h01, 1'b0};
      send_word(8'h01, 1'b1, (t == 0) ? 1'b1 : 1'b0, 6'd4);
      for (int i = 0; i < 11; i++) begin
        for (int c = 0; c < 4; c++) begin
          checks++;
          if (TX_OUT !== exp[i] || Busy !== 1'b1) begin
            errors++;
            $display("FAIL parity_t%0d bit %0d cyc %0d: TX_OUT=%b Busy=%b want %b 1",
                     t, i, c, TX_OUT, Busy, exp[i]);
          end
          @(negedge CLK);
        end
      end
      checks++;
      if (Busy !== 1'b0) begin errors++; $display("FAIL parity_end_t%0d: Busy=%b want 0", t, Busy); end
    end
  endtask

  task automatic test_no_parity_p16;
    logic [9:0] exp;
    exp = {1'b1, 8'hFF, 1'b0};
    send_word(8'hFF, 1'b0, 1'b0, 6'd16);
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < 16; c++) begin
        checks++;
        if (TX_OUT !== exp[i] || Busy !== 1'b1) begin
          errors++;
          $display("FAIL ff_frame bit %0d cyc %0d: TX_OUT=%b Busy=%b want %b 1",
                   i, c, TX_OUT, Busy, exp[i]);
        end
        @(negedge CLK);
      end
    end
    checks++;
    if (Busy !== 1'b0 || TX_OUT !== 1'b1) begin
      errors++; $display("FAIL ff_end: Busy=%b TX_OUT=%b want 0 1", Busy, TX_OUT);
    end
  endtask

  task automatic test_prescale_clamp;
    logic [9:0] exp;
    exp = {1'b1, 8'h96, 1'b0};
    send_word(8'h96, 1'b0, 1'b0, 6'd0);  // 0 is treated as 2
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < 2; c++) begin
        checks++;
        if (TX_OUT !== exp[i] || Busy !== 1'b1) begin
          errors++;
          $display("FAIL clamp bit %0d cyc %0d: TX_OUT=%b Busy=%b want %b 1",
                   i, c, TX_OUT, Busy, exp[i]);
        end
        @(negedge CLK);
      end
    end
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL clamp_end: Busy=%b want 0", Busy); end
  endtask

  task automatic test_reset_midframe;
    logic [10:0] exp;
    send_word(8'hC3, 1'b0, 1'b0, 6'd8);
    repeat (27) @(negedge CLK);  // 4th cycle of data bit 2
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    checks++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0 || Data_Ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: TX_OUT=%b Busy=%b Ready=%b want 1 0 1", TX_OUT, Busy, Data_Ready);
    end
    // 0x3C has four set bits: odd type -> parity 1
    exp = {1'b1, 1'b1, 8'h3C, 1'b0};
    send_word(8'h3C, 1'b1, 1'b1, 6'd8);
    for (int i = 0; i < 11; i++) begin
      for (int c = 0; c < 8; c++) begin
        checks++;
        if (TX_OUT !== exp[i] || Busy !== 1'b1) begin
          errors++;
          $display("FAIL after_reset bit %0d cyc %0d: TX_OUT=%b Busy=%b want %b 1",
                   i, c, TX_OUT, Busy, exp[i]);
        end
        @(negedge CLK);
      end
    end
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL after_reset_end: Busy=%b want 0", Busy); end
  endtask

`ifndef UART_TX_HOLD_EN
  task automatic test_busy_ignore;
    logic [9:0] exp;
    exp = {1'b1, 8'h0F, 1'b0};
    send_word(8'h0F, 1'b0, 1'b0, 6'd4);
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (TX_OUT !== exp[i] || Busy !== 1'b1) begin
          errors++;
          $display("FAIL ignore bit %0d cyc %0d: TX_OUT=%b Busy=%b want %b 1",
                   i, c, TX_OUT, Busy, exp[i]);
        end
        if (i * 4 + c == 20) begin P_DATA = 8'h00; Data_Valid = 1'b1; end
        if (i * 4 + c == 21) Data_Valid = 1'b0;
        @(negedge CLK);
      end
    end
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (TX_OUT !== 1'b1 || Busy !== 1'b0) begin
        errors++;
        $display("FAIL ignore_idle cyc %0d: TX_OUT=%b Busy=%b want 1 0", k, TX_OUT, Busy);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] exp;
    exp = {1'b1, 8'h81, 1'b0};
    send_word(8'h18, 1'b0, 1'b0, 6'd2);
    repeat (18) @(negedge CLK);      // into the stop bit
    P_DATA = 8'h81; Data_Valid = 1'b1;  // held until accepted
    repeat (2) @(negedge CLK);
    checks++;
    if (TX_OUT !== 1'b1 || Busy !== 1'b0 || Data_Ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap: TX_OUT=%b Busy=%b Ready=%b want 1 0 1", TX_OUT, Busy, Data_Ready);
    end
    @(negedge CLK);
    Data_Valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < 2; c++) begin
        checks++;
        if (TX_OUT !== exp[i] || Busy !== 1'b1) begin
          errors++;
          $display("FAIL b2b bit %0d cyc %0d: TX_OUT=%b Busy=%b want %b 1",
                   i, c, TX_OUT, Busy, exp[i]);
        end
        @(negedge CLK);
      end
    end
    checks++;
    if (Busy !== 1'b0) begin errors++; $display("FAIL b2b_end: Busy=%b want 0", Busy); end
  endtask
`else
  task automatic test_hold;
    logic [19:0] exp;
    bit          want_ready;
    exp = {1'b1, 8'h0F, 1'b0, 1'b1, 8'h55, 1'b0};
    send_word(8'h55, 1'b0, 1'b0, 6'd4);
    for (int i = 0; i < 20; i++) begin
      for (int c = 0; c < 4; c++) begin
        want_ready = !((i * 4 + c) >= 11 && (i * 4 + c) <= 39);
        checks++;
        if (TX_OUT !== exp[i] || Busy !== 1'b1 || Data_Ready !== want_ready) begin
          errors++;
          $display("FAIL hold bit %0d cyc %0d: TX_OUT=%b Busy=%b Ready=%b want %b 1 %b",
                   i, c, TX_OUT, Busy, Data_Ready, exp[i], want_ready);
        end
        if (i * 4 + c == 10) begin
          P_DATA = 8'h0F; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
        end
        if (i * 4 + c == 11) Data_Valid = 1'b0;
        @(negedge CLK);
      end
    end
    checks++;
    if (Busy !== 1'b0 || Data_Ready !== 1'b1) begin
      errors++; $display("FAIL hold_end: Busy=%b Ready=%b want 0 1", Busy, Data_Ready);
    end
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    test_reset;
    test_frame_a5;
    test_parity;
    test_no_parity_p16;
    test_prescale_clamp;
    test_reset_midframe;
`ifndef UART_TX_HOLD_EN
    test_busy_ignore;
    test_back_to_back;
`else
    test_hold;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
